// File: rtl/bw_edge_interp.sv
// Linear interpolation of the -THRESHOLD_DB crossing between two bracketing bins.
// One request at a time; quotient is produced by a 1-bit/clk restoring divider.
module bw_edge_interp #(
    parameter int ACCUM_WIDTH    = 18,
    parameter int FREQ_BIN_WIDTH = 16,
    parameter int FRAC_BITS      = 4,
    parameter int THRESHOLD_DB   = 7680
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  valid_i,
    input  logic [FREQ_BIN_WIDTH-1:0]             f1_i,
    input  logic [FREQ_BIN_WIDTH-1:0]             f2_i,
    input  logic signed [ACCUM_WIDTH-1:0]         L1_i,
    input  logic signed [ACCUM_WIDTH-1:0]         L2_i,
    output logic [FREQ_BIN_WIDTH+FRAC_BITS-1:0]   f_edge_o,
    output logic                                  degenerate_o,
    output logic                                  valid_o,
    output logic                                  busy_o
);
    localparam int NW = ACCUM_WIDTH + 1;
    localparam int FW = FREQ_BIN_WIDTH + 1;
    localparam int PW = NW + FREQ_BIN_WIDTH;
    localparam int QW = PW + FRAC_BITS;
    localparam int OW = FREQ_BIN_WIDTH + FRAC_BITS;
    localparam int RW = QW + 2;
    localparam int CW = $clog2(QW + 1);
    localparam logic signed [NW-1:0] TH = NW'(-THRESHOLD_DB);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

    state_t                      state_q;
    logic [FREQ_BIN_WIDTH-1:0]   f1_q, f2_q;
    logic signed [ACCUM_WIDTH-1:0] l1_q, l2_q;
    logic [QW-1:0]               pq_q;
    logic [NW-1:0]               rem_q, d_q;
    logic [CW-1:0]               cnt_q;
    logic                        sgn_q, deg_q, fin_q, fdeg_q;
    logic [OW-1:0]               res_q;

    // LOAD stage: signed differences, magnitudes and result sign
    logic signed [NW-1:0] n_w, dl_w, n_neg, dl_neg;
    logic signed [FW-1:0] df_w, df_neg;
    logic [NW-1:0]        n_mag, dl_mag;
    logic [FREQ_BIN_WIDTH-1:0] df_mag;
    logic [PW-1:0]        prod;
    logic                 sgn_c;

    always_comb begin
        n_w    = TH - {l1_q[ACCUM_WIDTH-1], l1_q};
        dl_w   = {l2_q[ACCUM_WIDTH-1], l2_q} - {l1_q[ACCUM_WIDTH-1], l1_q};
        df_w   = {1'b0, f2_q} - {1'b0, f1_q};
        n_neg  = -n_w;
        dl_neg = -dl_w;
        df_neg = -df_w;
        n_mag  = n_w[NW-1] ? n_neg : n_w;
        dl_mag = dl_w[NW-1] ? dl_neg : dl_w;
        df_mag = df_w[FW-1] ? df_neg[FREQ_BIN_WIDTH-1:0] : df_w[FREQ_BIN_WIDTH-1:0];
        prod   = {{FREQ_BIN_WIDTH{1'b0}}, n_mag} * {{NW{1'b0}}, df_mag};
        sgn_c  = (n_w != '0) && (dl_w != '0) && (df_w != '0) &&
                 (n_w[NW-1] ^ dl_w[NW-1] ^ df_w[FW-1]);
    end

    // Restoring divider step: the partial remainder always stays below D, so NW bits suffice
    logic [NW:0]   rem_sh, rem_sub;
    logic          ge;
    always_comb begin
        rem_sh  = {rem_q, pq_q[QW-1]};
        ge      = rem_sh >= {1'b0, d_q};
        rem_sub = rem_sh - {1'b0, d_q};
    end

    // DONE stage: apply sign around f1 and clamp into the bracket
    logic signed [RW-1:0] base, q_ext, lo, hi, r;
    logic [OW-1:0]        res_c;
    always_comb begin
        base  = $signed({{(RW-OW){1'b0}}, f1_q, {FRAC_BITS{1'b0}}});
        q_ext = $signed({2'b00, pq_q});
        if (f1_q <= f2_q) begin
            lo = base;
            hi = $signed({{(RW-OW){1'b0}}, f2_q, {FRAC_BITS{1'b0}}});
        end else begin
            lo = $signed({{(RW-OW){1'b0}}, f2_q, {FRAC_BITS{1'b0}}});
            hi = base;
        end
        r = sgn_q ? base - q_ext : base + q_ext;
        if (r < lo)      res_c = lo[OW-1:0];
        else if (r > hi) res_c = hi[OW-1:0];
        else             res_c = r[OW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            f1_q         <= '0;
            f2_q         <= '0;
            l1_q         <= '0;
            l2_q         <= '0;
            pq_q         <= '0;
            rem_q        <= '0;
            d_q          <= '0;
            cnt_q        <= '0;
            sgn_q        <= 1'b0;
            deg_q        <= 1'b0;
            fin_q        <= 1'b0;
            fdeg_q       <= 1'b0;
            res_q        <= '0;
            f_edge_o     <= '0;
            degenerate_o <= 1'b0;
            valid_o      <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            // Result is staged one clock past DONE before being presented
            fin_q   <= 1'b0;
            valid_o <= fin_q;
            if (fin_q) begin
                f_edge_o     <= res_q;
                degenerate_o <= fdeg_q;
            end
            case (state_q)
                S_IDLE: if (valid_i && !valid_o) begin
                    f1_q    <= f1_i;
                    f2_q    <= f2_i;
                    l1_q    <= L1_i;
                    l2_q    <= L2_i;
                    busy_o  <= 1'b1;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    d_q   <= dl_mag;
                    rem_q <= '0;
                    cnt_q <= '0;
                    if (dl_w == '0) begin
                        deg_q   <= 1'b1;
                        sgn_q   <= 1'b0;
                        pq_q    <= '0;
                        state_q <= S_DONE;
                    end else begin
                        deg_q   <= 1'b0;
                        sgn_q   <= sgn_c;
                        pq_q    <= {prod, {FRAC_BITS{1'b0}}};
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= ge ? rem_sub[NW-1:0] : rem_sh[NW-1:0];
                    pq_q  <= {pq_q[QW-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(QW-1)) state_q <= S_DONE;
                end
                S_DONE: begin
                    res_q   <= res_c;
                    fdeg_q  <= deg_q;
                    fin_q   <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
